// File: rtl/fib_req_master.sv
// fib_req_master: initiator for the fibonacci engine's load/done/clear
// protocol. Takes one job at a time from a valid/ready request port, loads
// it into the engine, waits (bounded by a timeout) for done/error, returns
// the result on a valid/ready response port and then clears the engine.
module fib_req_master #(
  parameter int DATA_WIDTH     = 64,
  parameter int FIB_ORDER      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [FIB_ORDER-1:0]  req_order,
  input  logic [DATA_WIDTH-1:0] req_seed,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [1:0]            rsp_status,
  output logic [15:0]           rsp_cycles,
  output logic                  fib_load,
  output logic                  fib_clear,
  output logic [DATA_WIDTH-1:0] fib_data_in,
  output logic [FIB_ORDER-1:0]  fib_order,
  input  logic [DATA_WIDTH-1:0] fib_data_out,
  input  logic                  fib_done,
  input  logic                  fib_overflw,
  input  logic                  fib_error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_CLEAR = 3'd4
  } state_t;

  localparam logic [15:0] TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);
  localparam logic [1:0]  ST_OK  = 2'b00;
  localparam logic [1:0]  ST_OVF = 2'b01;
  localparam logic [1:0]  ST_ERR = 2'b10;
  localparam logic [1:0]  ST_TMO = 2'b11;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [15:0]           r_cnt;
  logic [15:0]           w_cnt_inc;
  logic                  w_term;
  logic                  w_timeout;
  logic [1:0]            w_status;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic [1:0]            r_rsp_status;
  logic [DATA_WIDTH-1:0] r_fib_data_in;
  logic [FIB_ORDER-1:0]  r_fib_order;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic                  r_fib_load;
  logic                  r_fib_clear;

  // Saturating WAIT-cycle increment, termination decode and status priority.
  always_comb begin
    w_cnt_inc = r_cnt;
    w_status  = ST_OK;
    if (r_cnt == 16'hFFFF) begin
      w_cnt_inc = r_cnt;
    end else begin
      w_cnt_inc = r_cnt + 16'd1;
    end
    w_term    = fib_done | fib_error;
    w_timeout = (w_cnt_inc >= TIMEOUT_VAL);
    // error outranks overflow, which outranks a clean result
    if (fib_error) begin
      w_status = ST_ERR;
    end else if (fib_overflw) begin
      w_status = ST_OVF;
    end else begin
      w_status = ST_OK;
    end
  end

  // Next-state logic of the job sequencer.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (req_valid) w_state_nxt = S_LOAD;
        else           w_state_nxt = S_IDLE;
      end
      S_LOAD:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (w_term || w_timeout) w_state_nxt = S_RESP;
        else                     w_state_nxt = S_WAIT;
      end
      S_RESP: begin
        if (rsp_ready) w_state_nxt = S_CLEAR;
        else           w_state_nxt = S_RESP;
      end
      S_CLEAR: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Job latch, WAIT-cycle counter and result capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fib_order   <= {FIB_ORDER{1'b0}};
      r_fib_data_in <= {DATA_WIDTH{1'b0}};
      r_cnt         <= 16'd0;
      r_rsp_data    <= {DATA_WIDTH{1'b0}};
      r_rsp_status  <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_fib_order   <= req_order;
            r_fib_data_in <= req_seed;
          end
        end
        S_LOAD: r_cnt <= 16'd0;
        S_WAIT: begin
          r_cnt <= w_cnt_inc;
          // a result arriving on the timeout cycle still wins
          if (w_term) begin
            r_rsp_data   <= fib_data_out;
            r_rsp_status <= w_status;
          end else if (w_timeout) begin
            r_rsp_data   <= {DATA_WIDTH{1'b0}};
            r_rsp_status <= ST_TMO;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Registered handshake and strobe outputs decoded from the next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_fib_load  <= 1'b0;
      r_fib_clear <= 1'b0;
    end else begin
      r_req_ready <= (w_state_nxt == S_IDLE);
      r_rsp_valid <= (w_state_nxt == S_RESP);
      r_fib_load  <= (w_state_nxt == S_LOAD);
      r_fib_clear <= (w_state_nxt == S_CLEAR);
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_status  = r_rsp_status;
  assign rsp_cycles  = r_cnt;
  assign fib_load    = r_fib_load;
  assign fib_clear   = r_fib_clear;
  assign fib_data_in = r_fib_data_in;
  assign fib_order   = r_fib_order;

endmodule

// File: tb/tb_fib_req_master.sv
// Bench for fib_req_master: a behavioural engine model answers loads after a
// configured latency; each job's expected response is computed from the
// job parameters and compared with what the master returns.
module tb_fib_req_master;
  localparam int DW = 64;
  localparam int OW = 16;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          req_valid;
  logic          req_ready;
  logic [OW-1:0] req_order;
  logic [DW-1:0] req_seed;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [1:0]    rsp_status;
  logic [15:0]   rsp_cycles;
  logic          fib_load;
  logic          fib_clear;
  logic [DW-1:0] fib_data_in;
  logic [OW-1:0] fib_order;
  logic [DW-1:0] fib_data_out;
  logic          fib_done;
  logic          fib_overflw;
  logic          fib_error;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int load_cnt;
  int clear_cnt;

  // engine behaviour for the current job (written by the main sequence only)
  int   eng_lat;
  logic eng_dn;
  logic eng_err;
  logic eng_ovf;

  fib_req_master #(.DATA_WIDTH(DW), .FIB_ORDER(OW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_order(req_order), .req_seed(req_seed),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_status(rsp_status), .rsp_cycles(rsp_cycles),
    .fib_load(fib_load), .fib_clear(fib_clear),
    .fib_data_in(fib_data_in), .fib_order(fib_order),
    .fib_data_out(fib_data_out), .fib_done(fib_done),
    .fib_overflw(fib_overflw), .fib_error(fib_error)
  );

  always #5 clk = ~clk;

  // free-running cycle count for spacing measurements
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic logic [63:0] fib_ref(input logic [15:0] n);
    logic [63:0] a, b, t;
    a = 64'd0;
    b = 64'd1;
    for (int i = 0; i < int'(n); i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Engine model plus load/clear pulse counters, all on the falling edge.
  initial begin
    int   wcnt;
    logic armed;
    fib_done = 1'b0; fib_error = 1'b0; fib_overflw = 1'b0;
    fib_data_out = 64'd0;
    load_cnt = 0; clear_cnt = 0; armed = 1'b0; wcnt = 0;
    forever begin
      @(negedge clk);
      if (fib_load)  load_cnt++;
      if (fib_clear) clear_cnt++;
      if (reset) begin
        armed = 1'b0;
        fib_done = 1'b0; fib_error = 1'b0; fib_overflw = 1'b0;
        fib_data_out = 64'd0;
      end else if (fib_clear) begin
        armed = 1'b0;
        fib_done = 1'b0; fib_error = 1'b0; fib_overflw = 1'b0;
      end else if (fib_load) begin
        armed = 1'b1;
        wcnt = 0;
      end else if (armed) begin
        wcnt++;
        if (eng_lat != 0 && wcnt == eng_lat) begin
          armed = 1'b0;
          fib_done     = eng_dn;
          fib_error    = eng_err;
          fib_overflw  = eng_ovf;
          fib_data_out = fib_ref(fib_order) + fib_data_in - 64'd1;
        end
      end
    end
  end

  // One job end to end; the response is predicted from the job parameters.
  task automatic run_job(input string nm, input logic [15:0] ord, input logic [63:0] sd,
                         input int lat, input logic ovf, input logic er, input logic dn,
                         input int hold);
    logic [63:0] e_data;
    logic [1:0]  e_st;
    logic [15:0] e_cyc;
    int l0, c0, n;
    if (lat == 0 || lat > TO || (!dn && !er)) begin
      e_data = 64'd0; e_st = 2'b11; e_cyc = 16'(TO);
    end else begin
      e_data = fib_ref(ord) + sd - 64'd1;
      e_st   = er ? 2'b10 : (ovf ? 2'b01 : 2'b00);
      e_cyc  = 16'(lat);
    end
    eng_lat = lat; eng_ovf = ovf; eng_err = er; eng_dn = dn;
    n = 0;
    while (!req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_req_ready"}, req_ready, 1);
    l0 = load_cnt; c0 = clear_cnt;
    req_valid = 1'b1; req_order = ord; req_seed = sd;
    @(negedge clk);
    req_valid = 1'b0;
    chk({nm, "_load"}, fib_load, 1);
    chk({nm, "_busy"}, req_ready, 0);
    n = 0;
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_rsp_valid"}, rsp_valid, 1);
    chk({nm, "_data"}, rsp_data, e_data);
    chk({nm, "_status"}, rsp_status, e_st);
    chk({nm, "_cycles"}, rsp_cycles, e_cyc);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk({nm, "_hold_valid"}, rsp_valid, 1);
      chk({nm, "_hold_ready"}, req_ready, 0);
      chk({nm, "_hold_data"}, rsp_data, e_data);
      chk({nm, "_hold_status"}, rsp_status, e_st);
      chk({nm, "_hold_cycles"}, rsp_cycles, e_cyc);
      chk({nm, "_hold_noclear"}, clear_cnt - c0, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({nm, "_clear"}, fib_clear, 1);
    chk({nm, "_rsp_drop"}, rsp_valid, 0);
    @(negedge clk);
    chk({nm, "_loads"}, load_cnt - l0, 1);
    chk({nm, "_clears"}, clear_cnt - c0, 1);
  endtask

  initial begin
    logic [63:0] b2b_q[$];
    int hs[3];
    int k, l0, c0, n, lat, r;
    logic [63:0] sd;
    eng_lat = 0; eng_dn = 1'b1; eng_err = 1'b0; eng_ovf = 1'b0;
    reset = 1'b1; rsp_ready = 1'b0;
    req_valid = 1'b1; req_order = 16'd10; req_seed = 64'd1;
    repeat (4) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_load", fib_load, 0);
    chk("rst_clear", fib_clear, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_status", rsp_status, 0);
    chk("rst_rsp_cycles", rsp_cycles, 0);
    chk("rst_fib_order", fib_order, 0);
    chk("rst_fib_data_in", fib_data_in, 0);
    chk("rst_no_loads", load_cnt, 0);
    req_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);

    run_job("basic", 16'd10, 64'd1, 12, 1'b0, 1'b0, 1'b1, 0);
    run_job("ovf", 16'd93, 64'd1, 4, 1'b1, 1'b0, 1'b1, 0);
    run_job("err_ovf", 16'd93, 64'd1, 4, 1'b1, 1'b1, 1'b1, 0);
    run_job("timeout", 16'd7, 64'd3, 0, 1'b0, 1'b0, 1'b0, 0);
    run_job("after_to", 16'd11, 64'd2, 1, 1'b0, 1'b0, 1'b1, 0);
    run_job("backpr", 16'd8, 64'd2, 5, 1'b0, 1'b0, 1'b1, 7);
    run_job("err_only", 16'd9, 64'd5, 3, 1'b0, 1'b1, 1'b0, 0);

    for (int i = 0; i < 10; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      lat = 0;
      else if (r == 1) lat = int'($urandom_range(21, 30));
      else             lat = int'($urandom_range(1, 19));
      sd = {32'($urandom), 32'($urandom)};
      run_job($sformatf("rnd%0d", i), 16'($urandom_range(0, 100)), sd, lat,
              1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 4) != 0),
              int'($urandom_range(0, 3)));
    end

    // back-to-back jobs with both handshakes always ready
    eng_lat = 1; eng_dn = 1'b1; eng_err = 1'b0; eng_ovf = 1'b0;
    l0 = load_cnt; c0 = clear_cnt; k = 0;
    rsp_ready = 1'b1;
    req_seed = 64'd1;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (rsp_valid) b2b_q.push_back(rsp_data);
      if (req_ready) begin
        if (k < 3) begin
          req_valid = 1'b1;
          req_order = 16'(5 + k);
          hs[k] = cyc;
          k++;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    chk("b2b_count", b2b_q.size(), 3);
    for (int i = 0; i < b2b_q.size() && i < 3; i++)
      chk($sformatf("b2b_data%0d", i), b2b_q[i], fib_ref(16'(5 + i)));
    chk("b2b_gap01", hs[1] - hs[0], 5);
    chk("b2b_gap12", hs[2] - hs[1], 5);
    chk("b2b_loads", load_cnt - l0, 3);
    chk("b2b_clears", clear_cnt - c0, 3);

    // reset while the master waits on a silent engine
    eng_lat = 0;
    @(negedge clk);
    req_valid = 1'b1; req_order = 16'd4; req_seed = 64'd9;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    c0 = clear_cnt;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_req_ready", req_ready, 1);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_load", fib_load, 0);
    chk("mid_rst_clear", fib_clear, 0);
    chk("mid_rst_cycles", rsp_cycles, 0);
    chk("mid_rst_order", fib_order, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    n = 0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clk);
      if (rsp_valid) n++;
    end
    chk("mid_rst_no_rsp", n, 0);
    chk("mid_rst_no_clear", clear_cnt - c0, 0);
    run_job("post_rst", 16'd12, 64'd1, 6, 1'b0, 1'b0, 1'b1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fib_req_master.md
Name: fib_req_master

Overview:
- Synthesizable initiator for the fibonacci engine's load/done/clear interface, i.e. the driving end of that protocol.
- Accepts jobs from an upstream valid/ready port and issues each one to the engine as a one-cycle load.
- Waits for done or error, bounded by a timeout, then captures the result and status.
- Returns the result on a downstream valid/ready port, then clears the engine before taking the next job.

Parameters:
- DATA_WIDTH, 64, width of the seed and result data.
- FIB_ORDER, 16, width of the order field.
- TIMEOUT_CYCLES, 1024, maximum number of WAIT cycles before the job is aborted; legal range 2..65535.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  upstream job valid.
- req_ready  out  1  master can accept a job.
- req_order  in  FIB_ORDER  requested Fibonacci order.
- req_seed  in  DATA_WIDTH  seed value passed to the engine.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accepts the result.
- rsp_data  out  DATA_WIDTH  captured engine data_out.
- rsp_status  out  2  00 OK, 01 OVERFLOW, 10 ERROR, 11 TIMEOUT.
- rsp_cycles  out  16  WAIT cycles spent on the job, saturating.
- fib_load  out  1  engine load strobe.
- fib_clear  out  1  engine clear strobe.
- fib_data_in  out  DATA_WIDTH  engine seed.
- fib_order  out  FIB_ORDER  engine order.
- fib_data_out  in  DATA_WIDTH  engine result.
- fib_done  in  1  engine done.
- fib_overflw  in  1  engine overflow flag.
- fib_error  in  1  engine error flag.

Behaviour:
- Reset values: all outputs are 0 except req_ready, which is 1. State is IDLE and all internal registers are 0.
- States and transitions:
  - IDLE: req_ready=1. When req_valid&req_ready, latch order and seed into fib_order/fib_data_in (held stable until the next accepted job) and go to LOAD.
  - LOAD: fib_load=1 for exactly one cycle. Clear the cycle counter. Go to WAIT.
  - WAIT: increment the cycle counter every cycle, saturating at 16'hFFFF. Exit on the first of the following:
    - fib_done or fib_error high: capture fib_data_out and status, go to RESP.
    - counter reaches TIMEOUT_CYCLES: status=11, rsp_data=0, go to RESP.
  - RESP: rsp_valid=1. rsp_data/rsp_status/rsp_cycles are stable while rsp_valid&!rsp_ready. On rsp_valid&rsp_ready go to CLEAR.
  - CLEAR: fib_clear=1 for exactly one cycle, then go to IDLE.
- Latency: fib_load rises 1 cycle after the request handshake. rsp_valid rises 1 cycle after done is sampled. fib_clear rises 1 cycle after the response handshake.
- Minimum job turnaround, with done on the first WAIT cycle and rsp_ready tied 1: 5 cycles from one req handshake to the next.
- req_ready is 1 only in IDLE; no job is ever accepted while one is outstanding.
- Status priority when sampled together: error > overflow > OK. With done=1, error=1, overflw=1 the status is 10.
- fib_error without fib_done still terminates the job with status 10, and fib_data_out is still captured.
- fib_done that is already high on the first WAIT cycle is accepted; it need not show a rising edge.
- fib_done/fib_error sampled in any state other than WAIT are ignored.
- rsp_cycles is the value 1 on the first WAIT cycle and counts inclusive of the terminating cycle. On timeout it equals TIMEOUT_CYCLES.
- Reset mid-operation: all state returns to IDLE immediately.
  - fib_load and fib_clear drop asynchronously.
  - An in-flight response is discarded.
  - The master issues no clear; the engine is reset by the same reset.
- No combinational path from any input to any output. All outputs are registered.

Test Plan:
- Reset with req_valid=1 -> req_ready=1, all other outputs 0, no fib_load until reset deasserts. Then job order=10, seed=1, engine model returns done with data_out=55 after 12 cycles -> single fib_load pulse, rsp_data=55, rsp_status=00, rsp_cycles=12, single fib_clear after rsp handshake.
- Order=93, engine returns done+overflw=1 -> rsp_status=01. Same job with error=1 also high -> rsp_status=10.
- Engine never responds, TIMEOUT_CYCLES=20 -> rsp_status=11, rsp_data=0, rsp_cycles=20, fib_clear pulses, next job accepted.
- rsp_ready held 0 for 7 cycles -> rsp_* stable, req_ready=0, no fib_clear until handshake.
- Back-to-back jobs (orders 5,6,7) with req_valid and rsp_ready tied 1 and done on first WAIT cycle -> results 5,8,13 in order, 5-cycle spacing, exactly one load and one clear per job.
- Reset asserted during WAIT -> outputs return to reset values the same cycle, no rsp_valid. The next job completes normally.
